psum_accumulator: RTL

//  Downstream consumer of the saturating adder stage in the systolic-array datapath.

---
 rtl/psum_pkg.sv | 51 +++++
 rtl/sync_fifo.sv | 55 +++++
 rtl/psum_accumulator.sv | 129 ++++++++++++
 3 files changed

// File: rtl/psum_pkg.sv
// Shared helpers for the partial-sum accumulator: saturating add, fixed-point align, parameter checks.
package psum_pkg;

    localparam int unsigned CALC_W = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } psum_state_t;

    typedef struct packed {
        logic              sat;
        logic [CALC_W-1:0] sum;
    } sat_res_t;

    function automatic logic [CALC_W-1:0] width_mask(input int unsigned width);
        return (width >= CALC_W) ? '1 : ((CALC_W'(1) << width) - CALC_W'(1));
    endfunction

    // Operands are expected to already fit in 'width' bits.
    function automatic sat_res_t sat_add_u(input logic [CALC_W-1:0] a,
                                           input logic [CALC_W-1:0] b,
                                           input int unsigned       width);
        logic [CALC_W:0] full;
        sat_res_t        r;
        full  = {1'b0, a} + {1'b0, b};
        r.sat = ((full & ~{1'b0, width_mask(width)}) != '0);
        r.sum = r.sat ? width_mask(width) : full[CALC_W-1:0];
        return r;
    endfunction

    function automatic logic [CALC_W-1:0] align_fx(input logic [CALC_W-1:0] val,
                                                   input int                shift,
                                                   input int unsigned       width);
        logic [CALC_W-1:0] r;
        if (shift >= 0)
            r = (shift >= int'(width)) ? '0 : ((val << shift) & width_mask(width));
        else
            r = (-shift >= int'(width)) ? '0 : (val >> (-shift));
        return r;
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit widths_ok(input int unsigned in_w, input int unsigned out_w);
        return (out_w >= in_w) && (out_w < CALC_W);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and registered occupancy count.
module sync_fifo
    import psum_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Power-of-2 depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates ACC_LEN adder beats into one saturating partial sum and queues results for a
// valid/ready consumer, stalling the adder chain when the result queue is full.
module psum_accumulator
    import psum_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 16,
    parameter int          IN_FRAC    = 0,
    parameter int unsigned OUT_WIDTH  = 24,
    parameter int          OUT_FRAC   = 0,
    parameter int unsigned ACC_LEN    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 flush,
    output logic                 stall_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 acc_busy,
    output logic                 sat_seen
);

    localparam int unsigned CNT_W = $clog2(ACC_LEN) + 1;
    localparam int          SHIFT = OUT_FRAC - IN_FRAC;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

    if (!widths_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_width
        $error("psum_accumulator: OUT_WIDTH must be >= IN_WIDTH and < 64");
    end
    if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
        $error("psum_accumulator: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (ACC_LEN < 1) begin : g_bad_len
        $error("psum_accumulator: ACC_LEN must be >= 1");
    end

    psum_state_t                 state;
    psum_state_t                 state_next;
    logic [CNT_W-1:0]            count;
    logic [CNT_W-1:0]            count_next;
    logic [OUT_WIDTH-1:0]        acc;
    logic [OUT_WIDTH-1:0]        acc_next;
    logic [OUT_WIDTH-1:0]        push_data;
    logic [OUT_WIDTH-1:0]        aligned;
    sat_res_t                    add_res;
    logic [CALC_W-OUT_WIDTH-1:0] unused_sum_hi;
    logic                        beat_ok;
    logic                        flush_ok;
    logic                        closing;
    logic                        push;
    logic                        pop;
    logic                        sat_hit;
    logic                        fifo_full;
    logic                        fifo_empty;

    assign stall_out     = fifo_full;
    assign out_valid     = !fifo_empty;
    assign pop           = out_valid && out_ready;
    assign beat_ok       = in_valid && !stall_out;
    assign flush_ok      = flush && !stall_out;
    assign aligned       = OUT_WIDTH'(align_fx(CALC_W'(in_data), SHIFT, OUT_WIDTH));
    assign add_res       = sat_add_u(CALC_W'(acc), CALC_W'(aligned), OUT_WIDTH);
    assign unused_sum_hi = add_res.sum[CALC_W-1:OUT_WIDTH];

    // Next-state: a closing beat or honoured flush pushes acc_next/acc and returns to IDLE.
    always_comb begin
        state_next = state;
        count_next = count;
        acc_next   = acc;
        push_data  = acc;
        sat_hit    = 1'b0;
        closing    = 1'b0;

        if (beat_ok) begin
            if (count == '0) begin
                acc_next = aligned;
            end else begin
                acc_next = add_res.sum[OUT_WIDTH-1:0];
                sat_hit  = add_res.sat;
            end
            closing    = (count == LAST);
            count_next = count + CNT_W'(1);
            push_data  = acc_next;
        end

        push = closing || (flush_ok && (beat_ok || count != '0));
        if (push) count_next = '0;

        case (state)
            IDLE:    if (beat_ok && !push) state_next = ACCUM;
            ACCUM:   if (push) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            acc_busy <= 1'b0;
            sat_seen <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            acc      <= acc_next;
            acc_busy <= (state_next == ACCUM);
            sat_seen <= sat_seen | sat_hit;
        end
    end

    sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
